// File: rtl/branch_pkg.sv
// Shared types for the branch resolve unit: queue entry layout, FSM states,
// and the default in-flight queue depth.
package branch_pkg;

  localparam int unsigned BR_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic        pred;
    logic [31:0] target;
    logic [31:0] fallthru;
  } br_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } br_state_t;

endpackage

// File: rtl/branch_fifo.sv
// In-flight branch queue: power-of-two depth FIFO with a synchronous clear
// that takes priority over a same-cycle push or pop.
module branch_fifo
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = BR_DEPTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic                           clear_i,
  input  logic [$bits(br_entry_t)-1:0]   wdata_i,
  output logic [$bits(br_entry_t)-1:0]   rdata_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  br_entry_t        mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= br_entry_t'(wdata_i);
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks in-flight branches from decode to MEM, compares predictions with
// outcomes, drives predictor updates, flush/redirect and statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH        = BR_DEPTH_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_branch,
  input  logic             dec_prediction,
  input  logic [31:0]      dec_target,
  input  logic [31:0]      dec_pc,
  input  logic             mem_branch,
  input  logic             mem_taken,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             stall,
  output logic             err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_t        state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [$bits(br_entry_t)-1:0] head_raw;
  br_entry_t        head;
  br_entry_t        wentry;

  logic             resolve_ok;
  logic             mispredict;
  logic             push;

  logic             upd_valid_q;
  logic             upd_taken_q;
  logic             flush_q;
  logic [31:0]      redirect_q;
  logic             err_q;
  logic [CNT_W-1:0] bcnt_q;
  logic [CNT_W-1:0] mcnt_q;

  assign head       = br_entry_t'(head_raw);
  assign wentry     = '{pred: dec_prediction, target: dec_target, fallthru: dec_pc + 32'd4};
  assign resolve_ok = mem_branch && (state_q == RUN) && !fifo_empty;
  assign mispredict = resolve_ok && (head.pred != mem_taken);
  // A mispredicting pop makes any same-cycle decode branch wrong-path.
  assign push       = dec_branch && (state_q == RUN) && !fifo_full && !mispredict;
  assign stall      = fifo_full;

  branch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (resolve_ok),
    .clear_i (mispredict),
    .wdata_i (wentry),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // The first FLUSH cycle is the flush pulse cycle itself.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d = FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = RUN;
        else              fcnt_d  = fcnt_q - FC_W'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_valid_q <= 1'b0;
      upd_taken_q <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      err_q       <= 1'b0;
      bcnt_q      <= '0;
      mcnt_q      <= '0;
    end else begin
      upd_valid_q <= resolve_ok;
      upd_taken_q <= resolve_ok && mem_taken;
      flush_q     <= mispredict;
      if (mispredict)                   redirect_q <= mem_taken ? head.target : head.fallthru;
      if (mem_branch && !resolve_ok)    err_q      <= 1'b1;
      if (resolve_ok && (bcnt_q != '1)) bcnt_q     <= bcnt_q + CNT_W'(1);
      if (mispredict && (mcnt_q != '1)) mcnt_q     <= mcnt_q + CNT_W'(1);
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_taken      = upd_taken_q;
  assign flush          = flush_q;
  assign redirect_pc    = redirect_q;
  assign err            = err_q;
  assign branch_cnt     = bcnt_q;
  assign mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// random traffic, all checked against a queue-based behavioural model.
module tb_branch_resolve_unit;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned CNT_W        = 4;
  localparam int          CMAX         = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             dec_branch;
  logic             dec_prediction;
  logic [31:0]      dec_target;
  logic [31:0]      dec_pc;
  logic             mem_branch;
  logic             mem_taken;
  logic             upd_valid;
  logic             upd_taken;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic             stall;
  logic             err;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  branch_resolve_unit #(
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dec_branch     (dec_branch),
    .dec_prediction (dec_prediction),
    .dec_target     (dec_target),
    .dec_pc         (dec_pc),
    .mem_branch     (mem_branch),
    .mem_taken      (mem_taken),
    .upd_valid      (upd_valid),
    .upd_taken      (upd_taken),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .err            (err),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  typedef struct {
    logic        pred;
    logic [31:0] tgt;
    logic [31:0] ret;
  } ent_t;

  ent_t        mq[$];
  int          flush_left;
  logic        e_valid, e_taken, e_flush, e_err;
  logic [31:0] e_redir;
  int          e_bcnt, e_mcnt;
  int          n_tests, n_fail;
  bit          primed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic db, input logic dp, input logic [31:0] dt,
                       input logic [31:0] dpc, input logic mb, input logic mt);
    dec_branch     = db;
    dec_prediction = dp;
    dec_target     = dt;
    dec_pc         = dpc;
    mem_branch     = mb;
    mem_taken      = mt;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  // Reference behaviour for one rising edge, from the current inputs.
  task automatic model_step();
    bit   run, pop, mis;
    int   sz;
    ent_t h;
    if (!rst_n) begin
      mq.delete();
      flush_left = 0;
      e_valid = 0; e_taken = 0; e_flush = 0; e_err = 0; e_redir = '0;
      e_bcnt = 0; e_mcnt = 0;
    end else begin
      run = (flush_left == 0);
      sz  = mq.size();
      pop = mem_branch && run && (sz > 0);
      mis = 0;
      e_valid = pop;
      e_taken = pop && mem_taken;
      e_flush = 0;
      if (mem_branch && !pop) e_err = 1;
      if (pop) begin
        h = mq.pop_front();
        if (e_bcnt < CMAX) e_bcnt++;
        if (h.pred != mem_taken) begin
          mis = 1;
          e_flush = 1;
          e_redir = mem_taken ? h.tgt : h.ret;
          if (e_mcnt < CMAX) e_mcnt++;
        end
      end
      if (flush_left > 0) flush_left--;
      if (mis) begin
        mq.delete();
        flush_left = FLUSH_CYCLES;
      end else if (dec_branch && run && (sz < DEPTH)) begin
        mq.push_back('{dec_prediction, dec_target, dec_pc + 32'd4});
      end
    end
  endtask

  task automatic tick();
    if (primed) chk("stall", stall, (mq.size() == DEPTH));
    model_step();
    @(posedge clk);
    #1;
    primed = 1;
    chk("upd_valid", upd_valid, e_valid);
    if (e_valid) chk("upd_taken", upd_taken, e_taken);
    chk("flush", flush, e_flush);
    if (e_flush || !rst_n) chk("redirect_pc", redirect_pc, e_redir);
    chk("err", err, e_err);
    chk("branch_cnt", branch_cnt, e_bcnt);
    chk("mispredict_cnt", mispredict_cnt, e_mcnt);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; primed = 0; flush_left = 0;
    e_valid = 0; e_taken = 0; e_flush = 0; e_err = 0; e_redir = '0;
    e_bcnt = 0; e_mcnt = 0;

    rst_n = 1'b0;
    idle(2);
    chk("rst_stall", stall, 0);
    chk("rst_redirect", redirect_pc, 0);
    rst_n = 1'b1;

    // Correctly predicted taken branch
    drive(1, 1, 32'h200, 32'h100, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 1); tick();
    chk("t36_upd_valid", upd_valid, 1);
    chk("t36_upd_taken", upd_taken, 1);
    chk("t36_flush", flush, 0);
    chk("t36_bcnt", branch_cnt, 1);

    // Mispredicted taken branch; decode pushes during FLUSH must vanish
    drive(1, 1, 32'h200, 32'h100, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    chk("t37_flush", flush, 1);
    chk("t37_redirect", redirect_pc, 32'h104);
    chk("t37_mcnt", mispredict_cnt, 1);
    drive(1, 0, 32'h300, 32'h300, 0, 0); tick();
    chk("t37_flush_once", flush, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h400 + 32'(i * 16), 32'h400 + 32'(i * 16), 0, 0);
      tick();
    end
    chk("t37_not_full", stall, 0);
    drive(0, 0, 0, 0, 1, 0);
    repeat (3) tick();

    // Fill, drop on full, pop then refill, check FIFO order
    for (int i = 0; i < 5; i++) begin
      drive(1, ~i[0], 32'h2000 + 32'(4 * i), 32'h1000 + 32'(4 * i), 0, 0);
      tick();
      if (i == 3) chk("t38_full", stall, 1);
    end
    drive(0, 0, 0, 0, 1, 1); tick();
    chk("t38_after_pop", stall, 0);
    drive(1, 1, 32'h2100, 32'h1100, 0, 0); tick();
    chk("t38_refull", stall, 1);
    drive(0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    chk("t38_no_flush", flush, 0);
    drive(0, 0, 0, 0, 1, 0); tick();
    chk("t38_last_redirect", redirect_pc, 32'h1104);
    idle(2);

    // Address wrap at the top of the address space
    drive(1, 0, 32'h40, 32'hFFFF_FFFC, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 1); tick();
    chk("t39_redirect_taken", redirect_pc, 32'h40);
    idle(2);
    drive(1, 1, 32'h40, 32'hFFFF_FFFC, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    chk("t39_redirect_wrap", redirect_pc, 32'h0);
    idle(2);

    // Empty-queue resolve, sticky error
    drive(0, 0, 0, 0, 1, 0); tick();
    chk("t40_upd_valid", upd_valid, 0);
    chk("t40_err", err, 1);
    idle(3);
    chk("t40_err_sticky", err, 1);

    // Reset with two entries queued and a resolve pending
    drive(1, 1, 32'h500, 32'h600, 0, 0); tick(); tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1, 1); tick();
    rst_n = 1'b1;
    chk("t40_rst_valid", upd_valid, 0);
    chk("t40_rst_err", err, 0);
    chk("t40_rst_bcnt", branch_cnt, 0);
    chk("t40_rst_stall", stall, 0);
    drive(0, 0, 0, 0, 1, 1); tick();
    chk("t40_rst_discard", upd_valid, 0);

    // Reset mid-FLUSH aborts the flush
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    drive(1, 1, 32'h700, 32'h800, 0, 0); tick(); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    chk("t40_pre_flush", flush, 1);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0); tick();
    rst_n = 1'b1;
    chk("t40_mid_flush", flush, 0);
    chk("t40_mid_redirect", redirect_pc, 0);
    chk("t40_mid_mcnt", mispredict_cnt, 0);
    drive(1, 0, 32'h900, 32'h910, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    chk("t40_run_after_rst", upd_valid, 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 99) < 60,
            1'($urandom),
            $urandom,
            ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom,
            $urandom_range(0, 99) < 45,
            1'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
